bus_sequencer: RTL and testbench

Control sequencer for the CPU datapath. It steps one instruction at a time through fetch and register-register execute by driving the 5-bit select of the 32:1 bus multiplexer and the load strobes of the registers on the bus. It sits between the top-level run control, memory, and the datapath, and is the only block that drives the bus select.

---
 rtl/bus_sequencer_if.sv | 47 ++++
 rtl/bus_sequencer.sv | 163 ++++++++++++++++
 tb/tb_bus_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sequencer_if.sv
// Bus sequencer interface.
// Purpose: groups the run-control, memory-ready, IR and datapath strobe
// signals that pass between the sequencer and the rest of the CPU.
// Ports (signals):
//   start, mem_rdy, ir[31:0]          : driven toward the sequencer
//   bus_sel[4:0], mar_in, pc_in,
//   inc_pc, read, mdr_in, ir_in,
//   y_in, z_in, hi_in, lo_in,
//   r_in[15:0], alu_op[4:0],
//   busy, done, illegal               : driven by the sequencer
// Modports:
//   master : the sequencer's view (drives bus select and strobes)
//   slave  : the datapath / run-control view
interface bus_sequencer_if;
  logic        start;
  logic        mem_rdy;
  logic [31:0] ir;

  logic [4:0]  bus_sel;
  logic        mar_in;
  logic        pc_in;
  logic        inc_pc;
  logic        read;
  logic        mdr_in;
  logic        ir_in;
  logic        y_in;
  logic        z_in;
  logic        hi_in;
  logic        lo_in;
  logic [15:0] r_in;
  logic [4:0]  alu_op;
  logic        busy;
  logic        done;
  logic        illegal;

  modport master (
    input  start, mem_rdy, ir,
    output bus_sel, mar_in, pc_in, inc_pc, read, mdr_in, ir_in,
           y_in, z_in, hi_in, lo_in, r_in, alu_op, busy, done, illegal
  );

  modport slave (
    output start, mem_rdy, ir,
    input  bus_sel, mar_in, pc_in, inc_pc, read, mdr_in, ir_in,
           y_in, z_in, hi_in, lo_in, r_in, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/bus_sequencer.sv
// Bus sequencer.
// Purpose: steps one instruction at a time through fetch (T0-T2) and
// register-register execute (T3-T6). It is the only driver of the 32:1 bus
// mux select and it pulses the register load strobes on the bus.
// Ports:
//   clk    : datapath clock, all state changes on its rising edge
//   reset  : asynchronous, active-high; forces IDLE immediately
//   bus    : bus_sequencer_if.master (start/mem_rdy/ir in; bus_sel,
//            strobes, r_in, alu_op, busy, done, illegal out)
module bus_sequencer (
  input  logic                   clk,
  input  logic                   reset,
  bus_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } state_t;

  // Fixed mux select codes for the non-register-file bus sources.
  localparam logic [4:0] SEL_ZHI  = 5'd5;
  localparam logic [4:0] SEL_ZLOW = 5'd4;
  localparam logic [4:0] SEL_PC   = 5'd3;
  localparam logic [4:0] SEL_MDR  = 5'd2;
  localparam logic [4:0] SEL_R0   = 5'd23;

  localparam logic [4:0] OP_MUL        = 5'd15;
  localparam logic [4:0] OP_DIV        = 5'd16;
  localparam logic [4:0] OP_LAST_LEGAL = 5'd16;

  state_t state_q;
  state_t state_d;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       ir_unused;

  assign opcode    = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign ir_unused = ^bus.ir[14:0];

  // State register; reset aborts any instruction in flight and all outputs
  // fall back to their IDLE decode without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Outputs are a Moore decode of state_q,
  // except the T1 load of PC/MDR which waits on mem_rdy. Register sources
  // map to 23-n, which for a 4-bit n always lands in 8..23, so the undefined
  // mux inputs 24..31 can never be selected.
  always_comb begin
    state_d      = state_q;
    bus.bus_sel  = SEL_PC;
    bus.mar_in   = 1'b0;
    bus.pc_in    = 1'b0;
    bus.inc_pc   = 1'b0;
    bus.read     = 1'b0;
    bus.mdr_in   = 1'b0;
    bus.ir_in    = 1'b0;
    bus.y_in     = 1'b0;
    bus.z_in     = 1'b0;
    bus.hi_in    = 1'b0;
    bus.lo_in    = 1'b0;
    bus.r_in     = 16'h0000;
    bus.alu_op   = 5'd0;
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    bus.busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_T0;
        end
      end

      S_T0: begin
        bus.bus_sel = SEL_PC;
        bus.mar_in  = 1'b1;
        bus.inc_pc  = 1'b1;
        bus.z_in    = 1'b1;
        state_d     = S_T1;
      end

      // Memory wait loop: read stays asserted until the data is valid.
      S_T1: begin
        bus.bus_sel = SEL_ZLOW;
        bus.read    = 1'b1;
        if (bus.mem_rdy) begin
          bus.pc_in  = 1'b1;
          bus.mdr_in = 1'b1;
          state_d    = S_T2;
        end
      end

      S_T2: begin
        bus.bus_sel = SEL_MDR;
        bus.ir_in   = 1'b1;
        if (opcode <= OP_LAST_LEGAL) begin
          state_d = S_T3;
        end else begin
          bus.done    = 1'b1;
          bus.illegal = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_T3: begin
        bus.bus_sel = SEL_R0 - {1'b0, rb};
        bus.y_in    = 1'b1;
        state_d     = S_T4;
      end

      S_T4: begin
        bus.bus_sel = SEL_R0 - {1'b0, rc};
        bus.alu_op  = opcode;
        bus.z_in    = 1'b1;
        state_d     = S_T5;
      end

      // mul/div produce a 64-bit result that goes to LO/HI instead of Ra.
      S_T5: begin
        bus.bus_sel = SEL_ZLOW;
        if ((opcode == OP_MUL) || (opcode == OP_DIV)) begin
          bus.lo_in = 1'b1;
          state_d   = S_T6;
        end else begin
          bus.r_in = 16'h0001 << ra;
          bus.done = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_T6: begin
        bus.bus_sel = SEL_ZHI;
        bus.hi_in   = 1'b1;
        bus.done    = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Testbench for bus_sequencer.
// Purpose: drives directed instructions through the sequencer. Each stimulus
// pushes its expected per-cycle output vectors into a queue; an independent
// monitor pops and compares one vector for every busy cycle and checks the
// idle outputs in the cycle after an instruction ends.
module tb_bus_sequencer;

  typedef struct packed {
    logic [4:0]  bus_sel;
    logic [9:0]  strobes;
    logic [15:0] r_in;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;
    logic        illegal;
  } out_t;

  // Strobe bit order: mar_in pc_in inc_pc read mdr_in ir_in y_in z_in hi_in lo_in
  localparam logic [9:0] S_MAR  = 10'b1000000000;
  localparam logic [9:0] S_PC   = 10'b0100000000;
  localparam logic [9:0] S_INC  = 10'b0010000000;
  localparam logic [9:0] S_READ = 10'b0001000000;
  localparam logic [9:0] S_MDR  = 10'b0000100000;
  localparam logic [9:0] S_IR   = 10'b0000010000;
  localparam logic [9:0] S_Y    = 10'b0000001000;
  localparam logic [9:0] S_Z    = 10'b0000000100;
  localparam logic [9:0] S_HI   = 10'b0000000010;
  localparam logic [9:0] S_LO   = 10'b0000000001;

  localparam int K_ALU  = 0;
  localparam int K_LONG = 1;
  localparam int K_ILL  = 2;

  localparam out_t IDLE_VEC = '{bus_sel: 5'd3, strobes: 10'd0, r_in: 16'h0000,
                                alu_op: 5'd0, busy: 1'b0, done: 1'b0, illegal: 1'b0};

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  out_t exp_q[$];
  logic prev_busy;
  logic gap_pending;

  bus_sequencer_if bus_if();

  bus_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t v;
    v.bus_sel = bus_if.bus_sel;
    v.strobes = {bus_if.mar_in, bus_if.pc_in, bus_if.inc_pc, bus_if.read, bus_if.mdr_in,
                 bus_if.ir_in, bus_if.y_in, bus_if.z_in, bus_if.hi_in, bus_if.lo_in};
    v.r_in    = bus_if.r_in;
    v.alu_op  = bus_if.alu_op;
    v.busy    = bus_if.busy;
    v.done    = bus_if.done;
    v.illegal = bus_if.illegal;
    return v;
  endfunction

  function automatic out_t mk(input logic [4:0] sel, input logic [9:0] stb,
                              input logic [15:0] rin, input logic [4:0] alu,
                              input logic dn, input logic ill);
    out_t v;
    v.bus_sel = sel;
    v.strobes = stb;
    v.r_in    = rin;
    v.alu_op  = alu;
    v.busy    = 1'b1;
    v.done    = dn;
    v.illegal = ill;
    return v;
  endfunction

  task automatic check_output(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual sel=%0d stb=%b rin=%h alu=%0d b/d/i=%b%b%b required sel=%0d stb=%b rin=%h alu=%0d b/d/i=%b%b%b",
               name, act.bus_sel, act.strobes, act.r_in, act.alu_op, act.busy, act.done, act.illegal,
               exp.bus_sel, exp.strobes, exp.r_in, exp.alu_op, exp.busy, exp.done, exp.illegal);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: while the sequencer is busy (or a deliberate idle gap is queued)
  // each cycle consumes one expected vector. On the cycle busy drops, the
  // outputs must be at their idle values and the instruction's queue drained.
  always @(negedge clk) begin
    out_t act;
    out_t e;
    if (reset) begin
      prev_busy   = 1'b0;
      gap_pending = 1'b0;
    end else begin
      act = sample();
      if (gap_pending) begin
        gap_pending = 1'b0;
        check_int("single_idle_gap", int'(act.busy), 1);
      end
      if (act.busy || (exp_q.size() > 0 && exp_q[0].busy == 1'b0)) begin
        if (exp_q.size() == 0) begin
          check_int("unexpected_busy_cycle", int'(act.busy), 0);
        end else begin
          e = exp_q.pop_front();
          check_output("step", act, e);
          if (!e.busy) gap_pending = 1'b1;
        end
      end else if (prev_busy) begin
        check_output("idle_after_done", act, IDLE_VEC);
        check_int("queue_drained", exp_q.size(), 0);
      end
      prev_busy = act.busy;
    end
  end

  // Builds the expected cycle-by-cycle outputs of one instruction from
  // hand-computed select codes and register enables.
  task automatic push_expected(input logic [4:0] op, input int kind, input int waits,
                               input logic [4:0] rb_sel, input logic [4:0] rc_sel,
                               input logic [15:0] rin);
    exp_q.push_back(mk(5'd3, S_MAR | S_INC | S_Z, 16'h0, 5'd0, 1'b0, 1'b0));
    for (int i = 0; i < waits; i++)
      exp_q.push_back(mk(5'd4, S_READ, 16'h0, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(5'd4, S_READ | S_PC | S_MDR, 16'h0, 5'd0, 1'b0, 1'b0));
    if (kind == K_ILL) begin
      exp_q.push_back(mk(5'd2, S_IR, 16'h0, 5'd0, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(mk(5'd2, S_IR, 16'h0, 5'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(rb_sel, S_Y, 16'h0, 5'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(rc_sel, S_Z, 16'h0, op, 1'b0, 1'b0));
      if (kind == K_LONG) begin
        exp_q.push_back(mk(5'd4, S_LO, 16'h0, 5'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(5'd5, S_HI, 16'h0, 5'd0, 1'b1, 1'b0));
      end else begin
        exp_q.push_back(mk(5'd4, 10'd0, rin, 5'd0, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_if.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_int("done_within_budget", int'(n < 100), 1);
  endtask

  // One-cycle start pulse; mem_rdy is held low for the first 'waits' T1 cycles.
  task automatic apply_stimulus(input logic [4:0] op, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [3:0] rc,
                                input int kind, input int waits,
                                input logic [4:0] rb_sel, input logic [4:0] rc_sel,
                                input logic [15:0] rin);
    @(posedge clk); #1;
    bus_if.ir      = {op, ra, rb, rc, 15'h0};
    bus_if.start   = 1'b1;
    bus_if.mem_rdy = (waits == 0);
    push_expected(op, kind, waits, rb_sel, rc_sel, rin);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    if (waits > 0) begin
      repeat (waits + 1) @(posedge clk);
      #1;
      bus_if.mem_rdy = 1'b1;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of instructions.
  initial begin
    checks         = 0;
    failures       = 0;
    prev_busy      = 1'b0;
    gap_pending    = 1'b0;
    reset          = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.mem_rdy = 1'b1;
    bus_if.ir      = 32'h0;
    #1;
    check_output("reset_state", sample(), IDLE_VEC);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // add r1, r2, r3
    apply_stimulus(5'd0, 4'd1, 4'd2, 4'd3, K_ALU, 0, 5'd21, 5'd20, 16'h0002);
    // mul r6, r4, r5
    apply_stimulus(5'd15, 4'd6, 4'd4, 4'd5, K_LONG, 0, 5'd19, 5'd18, 16'h0000);
    // div r7, r9, r10 (highest legal opcode)
    apply_stimulus(5'd16, 4'd7, 4'd9, 4'd10, K_LONG, 0, 5'd14, 5'd13, 16'h0000);
    // op 1 r3, r1, r6 with three memory wait cycles
    apply_stimulus(5'd1, 4'd3, 4'd1, 4'd6, K_ALU, 3, 5'd22, 5'd17, 16'h0008);
    // illegal opcodes 20 and 17 (lowest illegal)
    apply_stimulus(5'd20, 4'd2, 4'd3, 4'd4, K_ILL, 0, 5'd0, 5'd0, 16'h0000);
    apply_stimulus(5'd17, 4'd2, 4'd3, 4'd4, K_ILL, 0, 5'd0, 5'd0, 16'h0000);

    // Asynchronous reset while in T4
    @(posedge clk); #1;
    bus_if.ir    = {5'd2, 4'd5, 4'd6, 4'd7, 15'h0};
    bus_if.start = 1'b1;
    push_expected(5'd2, K_ALU, 0, 5'd17, 5'd16, 16'h0020);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("reset_mid_instruction", sample(), IDLE_VEC);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    apply_stimulus(5'd2, 4'd5, 4'd6, 4'd7, K_ALU, 0, 5'd17, 5'd16, 16'h0020);

    // start held high across two instructions, register-code extremes
    @(posedge clk); #1;
    bus_if.ir    = {5'd3, 4'd0, 4'd15, 4'd0, 15'h0};
    bus_if.start = 1'b1;
    push_expected(5'd3, K_ALU, 0, 5'd8, 5'd23, 16'h0001);
    exp_q.push_back(IDLE_VEC);
    push_expected(5'd5, K_ALU, 0, 5'd23, 5'd8, 16'h8000);
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    bus_if.ir = {5'd5, 4'd15, 4'd0, 4'd15, 15'h0};
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_idle();

    repeat (2) @(posedge clk);
    check_int("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
